barcode_entry_collector: RTL

//  Upstream stage of the barcode-to-ProductID lookup. Collects four keypad digits into

---
 rtl/sale_terminal_pkg.sv | 22 ++
 rtl/entry_timer.sv | 31 +++
 rtl/barcode_entry_collector.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale terminal: entry FSM encoding,
// barcode length and the "no product" ProductID.
package sale_terminal_pkg;

  localparam int         BARCODE_LEN = 4;
  localparam logic [3:0] INVALID_PID = 4'hF;

  typedef logic [2:0] entry_state_t;

  localparam entry_state_t ST_IDLE    = 3'd0;
  localparam entry_state_t ST_COLLECT = 3'd1;
  localparam entry_state_t ST_CHECK   = 3'd2;
  localparam entry_state_t ST_ACCEPT  = 3'd3;
  localparam entry_state_t ST_REJECT  = 3'd4;

  function automatic logic digit_in_range(input logic [3:0] d,
                                          input logic [3:0] lo,
                                          input logic [3:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable down-counter shared by the inactivity timeout and the error hold.
// expire is high while the count sits at zero; load takes priority over counting.
module entry_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_r;

  // Count down towards zero while enabled, reload on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == {W{1'b0}});

endmodule

// File: rtl/barcode_entry_collector.sv
// Collects four keypad digits, samples the external lookup result and either
// presents a ProductID to the sale logic or holds a rejected-scan flag.
module barcode_entry_collector
  import sale_terminal_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int ERR_HOLD       = 25_000_000,
  parameter int DIGIT_MIN      = 1,
  parameter int DIGIT_MAX      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_digit,
  input  logic       key_strobe,
  input  logic       key_delete,
  input  logic       key_clear,
  input  logic [3:0] lut_product_id,
  input  logic       lut_valid,
  input  logic       product_ack,
  output logic [3:0] BarcodeDigit_0,
  output logic [3:0] BarcodeDigit_1,
  output logic [3:0] BarcodeDigit_2,
  output logic [3:0] BarcodeDigit_3,
  output logic [2:0] digit_count,
  output logic [3:0] product_id,
  output logic       product_valid,
  output logic       scan_error,
  output logic       scan_timeout,
  output logic       bad_digit
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > ERR_HOLD) ? TIMEOUT_CYCLES : ERR_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Timeout reload is one short because expiry is acted on at the edge after reaching zero.
  localparam logic [TMR_W-1:0] TOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] ERR_LOAD  = TMR_W'(ERR_HOLD);

  entry_state_t                   state_r, state_s;
  logic [BARCODE_LEN-1:0][3:0]    digits_r, digits_s;
  logic [2:0]                     count_r, count_s;
  logic [3:0]                     pid_r, pid_s;
  logic [3:0]                     product_id_r, product_id_s;
  logic                           product_valid_r, product_valid_s;
  logic                           scan_error_r, scan_error_s;
  logic                           scan_timeout_r, scan_timeout_s;
  logic                           bad_digit_r, bad_digit_s;
  logic                           tmr_load_s, tmr_en_s, tmr_expire_s;
  logic [TMR_W-1:0]               tmr_val_s;
  logic [1:0]                     last_idx_s;
  logic                           legal_s;

  entry_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .expire   (tmr_expire_s)
  );

  // Next-state, datapath and registered-output decode for the entry FSM.
  always_comb begin
    state_s         = state_r;
    digits_s        = digits_r;
    count_s         = count_r;
    pid_s           = pid_r;
    product_valid_s = 1'b0;
    product_id_s    = INVALID_PID;
    scan_error_s    = 1'b0;
    scan_timeout_s  = 1'b0;
    bad_digit_s     = 1'b0;
    tmr_load_s      = 1'b0;
    tmr_en_s        = 1'b0;
    tmr_val_s       = TOUT_LOAD;
    last_idx_s      = count_r[1:0] - 2'd1;
    legal_s         = digit_in_range(key_digit, 4'(DIGIT_MIN), 4'(DIGIT_MAX));
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        tmr_en_s = (state_r == ST_COLLECT);
        if (key_clear) begin
          digits_s = {(BARCODE_LEN*4){1'b0}};
          count_s  = 3'd0;
          state_s  = ST_IDLE;
        end else if (key_delete) begin
          if (state_r == ST_COLLECT) begin
            digits_s[last_idx_s] = 4'h0;
            count_s    = count_r - 3'd1;
            tmr_load_s = 1'b1;
            state_s    = (count_r == 3'd1) ? ST_IDLE : ST_COLLECT;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (key_strobe && legal_s) begin
          digits_s[count_r[1:0]] = key_digit;
          count_s    = count_r + 3'd1;
          tmr_load_s = 1'b1;
          state_s    = (count_r == 3'(BARCODE_LEN - 1)) ? ST_CHECK : ST_COLLECT;
        end else begin
          bad_digit_s = key_strobe;
          // An illegal strobe is not a key event, so it does not hold off the timeout.
          if ((state_r == ST_COLLECT) && tmr_expire_s) begin
            digits_s       = {(BARCODE_LEN*4){1'b0}};
            count_s        = 3'd0;
            scan_timeout_s = 1'b1;
            state_s        = ST_IDLE;
          end else begin
            state_s = state_r;
          end
        end
      end
      ST_CHECK: begin
        if (lut_valid) begin
          pid_s   = lut_product_id;
          state_s = ST_ACCEPT;
        end else begin
          tmr_load_s = 1'b1;
          tmr_val_s  = ERR_LOAD;
          state_s    = ST_REJECT;
        end
      end
      ST_ACCEPT: begin
        // An ack only counts once product_valid has actually been presented.
        if (key_clear || (product_ack && product_valid_r)) begin
          digits_s = {(BARCODE_LEN*4){1'b0}};
          count_s  = 3'd0;
          pid_s    = INVALID_PID;
          state_s  = ST_IDLE;
        end else begin
          product_valid_s = 1'b1;
          product_id_s    = pid_r;
        end
      end
      ST_REJECT: begin
        tmr_en_s = 1'b1;
        if (key_clear || tmr_expire_s) begin
          digits_s = {(BARCODE_LEN*4){1'b0}};
          count_s  = 3'd0;
          state_s  = ST_IDLE;
        end else begin
          scan_error_s = 1'b1;
        end
      end
      default: begin
        digits_s = {(BARCODE_LEN*4){1'b0}};
        count_s  = 3'd0;
        pid_s    = INVALID_PID;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State, digit store and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      digits_r        <= {(BARCODE_LEN*4){1'b0}};
      count_r         <= 3'd0;
      pid_r           <= INVALID_PID;
      product_id_r    <= INVALID_PID;
      product_valid_r <= 1'b0;
      scan_error_r    <= 1'b0;
      scan_timeout_r  <= 1'b0;
      bad_digit_r     <= 1'b0;
    end else begin
      state_r         <= state_s;
      digits_r        <= digits_s;
      count_r         <= count_s;
      pid_r           <= pid_s;
      product_id_r    <= product_id_s;
      product_valid_r <= product_valid_s;
      scan_error_r    <= scan_error_s;
      scan_timeout_r  <= scan_timeout_s;
      bad_digit_r     <= bad_digit_s;
    end
  end

  assign BarcodeDigit_0 = digits_r[0];
  assign BarcodeDigit_1 = digits_r[1];
  assign BarcodeDigit_2 = digits_r[2];
  assign BarcodeDigit_3 = digits_r[3];
  assign digit_count    = count_r;
  assign product_id     = product_id_r;
  assign product_valid  = product_valid_r;
  assign scan_error     = scan_error_r;
  assign scan_timeout   = scan_timeout_r;
  assign bad_digit      = bad_digit_r;

endmodule
